timebase_ctrl: RTL

TIMEBASE_CTRL -- requirements
Module: timebase_ctrl

---
 rtl/timebase_ctrl.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/timebase_ctrl.sv
// Programmable timebase: run/pause/idle sequencer driving a divide-by-div tick and square wave.
// Optional decade tick output enabled by defining TIMEBASE_DECADE_EN.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | counter, oClk and decade cleared; divisor loads apply at once
// RUN    | counter advances, oTick every div cycles, oClk toggles on tick
// PAUSE  | counter, oClk and decade frozen; oTick held low
// 2'b11  | unreachable; recovers to IDLE on the next edge
module timebase_ctrl #(
    parameter int WIDTH       = 16,
    parameter int DEFAULT_DIV = 5
) (
    input  logic             iClk,
    input  logic             iRst,
    input  logic             iStart,
    input  logic             iStop,
    input  logic             iPause,
    input  logic             iLoad,
    input  logic [WIDTH-1:0] iDiv,
    output logic             oAck,
    output logic             oErr,
    output logic             oTick,
    output logic             oClk,
    output logic [1:0]       oState,
    output logic             oTick10
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10,
        ST_BAD   = 2'b11
    } state_t;

    localparam logic [WIDTH-1:0] DIV_RST = WIDTH'(DEFAULT_DIV);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] div_q, div_d;
    logic [WIDTH-1:0] pdiv_q, pdiv_d;
    logic             pend_q, pend_d;
    logic             tick_q, tick_d;
    logic             clk_q, clk_d;
    logic             ack_q, ack_d;
    logic             err_q, err_d;

    logic             run_en;
    logic             wrap;
    logic             reject;
    logic             accept;
    logic             pend_any;
    logic [WIDTH-1:0] pend_val;
    logic             apply_pt;
    logic             apply;

    always_comb begin
        state_d = ST_IDLE;
        case (state_q)
            ST_IDLE: begin
                if (!iStop && iStart) state_d = ST_RUN;
                else                  state_d = ST_IDLE;
            end
            ST_RUN: begin
                if (iStop)       state_d = ST_IDLE;
                else if (iStart) state_d = ST_RUN;
                else if (iPause) state_d = ST_PAUSE;
                else             state_d = ST_RUN;
            end
            ST_PAUSE: begin
                if (iStop)       state_d = ST_IDLE;
                else if (iStart) state_d = ST_RUN;
                else             state_d = ST_PAUSE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // The counter only advances in cycles that stay in RUN, so a pause resumes on the same phase.
    always_comb begin
        run_en = (state_q == ST_RUN) && (state_d == ST_RUN);
        wrap   = run_en && (cnt_q == (div_q - ONE));
        cnt_d  = cnt_q;
        clk_d  = clk_q;
        tick_d = 1'b0;
        if (state_d == ST_IDLE) begin
            cnt_d = '0;
            clk_d = 1'b0;
        end else if (wrap) begin
            cnt_d  = '0;
            tick_d = 1'b1;
            clk_d  = ~clk_q;
        end else if (run_en) begin
            cnt_d = cnt_q + ONE;
        end
    end

    // A rejected load in the same cycle as an apply defers the apply, keeping oAck/oErr exclusive.
    always_comb begin
        reject   = iLoad && (iDiv == '0);
        accept   = iLoad && (iDiv != '0);
        pend_val = accept ? iDiv : pdiv_q;
        pend_any = accept || pend_q;
        apply_pt = ((state_q != ST_RUN) && (state_q != ST_PAUSE)) ||
                   (state_d == ST_IDLE) || wrap;
        apply    = pend_any && apply_pt && !reject;
        div_d    = div_q;
        pdiv_d   = pdiv_q;
        pend_d   = pend_q;
        ack_d    = 1'b0;
        err_d    = reject;
        if (apply) begin
            div_d  = pend_val;
            pend_d = 1'b0;
            ack_d  = 1'b1;
        end else if (pend_any) begin
            pend_d = 1'b1;
            pdiv_d = pend_val;
        end
    end

    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            div_q   <= DIV_RST;
            pdiv_q  <= '0;
            pend_q  <= 1'b0;
            tick_q  <= 1'b0;
            clk_q   <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            pdiv_q  <= pdiv_d;
            pend_q  <= pend_d;
            tick_q  <= tick_d;
            clk_q   <= clk_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
        end
    end

`ifdef TIMEBASE_DECADE_EN
    logic [3:0] dec_q, dec_d;
    logic       t10_q, t10_d;

    always_comb begin
        dec_d = dec_q;
        t10_d = 1'b0;
        if (state_d == ST_IDLE) begin
            dec_d = 4'd0;
        end else if (wrap) begin
            if (dec_q == 4'd9) begin
                dec_d = 4'd0;
                t10_d = 1'b1;
            end else begin
                dec_d = dec_q + 4'd1;
            end
        end
    end

    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            dec_q <= 4'd0;
            t10_q <= 1'b0;
        end else begin
            dec_q <= dec_d;
            t10_q <= t10_d;
        end
    end

    assign oTick10 = t10_q;
`else
    assign oTick10 = 1'b0;
`endif

    assign oState = state_q;
    assign oTick  = tick_q;
    assign oClk   = clk_q;
    assign oAck   = ack_q;
    assign oErr   = err_q;

endmodule
